// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a shared single-port
// memory with fixed access latency LAT; one transaction outstanding at a time.
module mem_arbiter #(
  parameter int unsigned LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_kill,
  output logic        i_rdy,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_rdy,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_d_q, last_d_d;   // 1: data port was granted last
  logic        gnt_d_q, gnt_d_d;     // 1: current transaction belongs to data port
  logic        kill_q, kill_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] ibuf_q, ibuf_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b0;
      gnt_d_q   <= 1'b0;
      kill_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ibuf_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      gnt_d_q   <= gnt_d_d;
      kill_q    <= kill_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ibuf_q    <= ibuf_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    gnt_d_d   = gnt_d_q;
    kill_d    = kill_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ibuf_d    = ibuf_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_d  = d_req && (!i_req || !last_d_q);
          state_d  = ISSUE;
          cnt_d    = CNT_LOAD;
          gnt_d_d  = grant_d;
          last_d_d = grant_d;
          kill_d   = 1'b0;
          addr_d   = grant_d ? d_addr : i_addr;
          we_d     = grant_d && d_we;
          if (grant_d) wdata_d = d_wdata;
        end
      end
      ISSUE, WAIT: begin
        if (!gnt_d_q && i_kill) kill_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          // Fetch data is parked in ibuf so a kill during DONE can still veto it.
          if (gnt_d_q) begin
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            ibuf_d = mem_rdata;
          end
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (i_rdy) i_rdata_d = ibuf_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdy     = (state_q == DONE) && !gnt_d_q && !kill_q && !i_kill;
  assign d_rdy     = (state_q == DONE) && gnt_d_q;
  assign i_rdata   = i_rdy ? ibuf_q : i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=4 instance driven by a vector table and
// hand sequences, plus a LAT=1 instance for back-to-back fetches.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LAT=4 instance signals
  logic        i_req = 0, i_kill = 0, d_req = 0, d_we = 0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_rdy, d_rdy, mem_en, mem_we, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // LAT=1 instance signals
  logic        i_req1 = 0, i_kill1 = 0, d_req1 = 0, d_we1 = 0;
  logic [15:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic        i_rdy1, d_rdy1, mem_en1, mem_we1, busy1;
  logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  mem_arbiter #(.LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_kill(i_kill1), .i_rdy(i_rdy1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdy(d_rdy1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Memory model: data valid only in the LAT-th cycle of an access, junk otherwise.
  logic [15:0] mem [256];
  int          age4 = 0;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {i[7:0], 8'h5A};
    mem[8'h10] = 16'hBEEF;
    mem[8'h40] = 16'hCAFE;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      age4 <= 2;
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end else if (age4 != 0 && age4 < 20) begin
      age4 <= age4 + 1;
    end
  end
  assign mem_rdata  = (age4 == 4) ? mem[mem_addr[7:0]] : 16'hDEAD;
  assign mem_rdata1 = mem_en1 ? mem[mem_addr1[7:0]] : 16'hDEAD;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int cyc, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    int          kill_mode;  // 0 none, 1 pulse in WAIT, 2 with request in IDLE, 3 in DONE
    logic [15:0] iaddr;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic        exp_i;
    logic        exp_d;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [15:0] exp_wdata;
    logic [15:0] exp_ird;
    logic [15:0] exp_drd;
  } vec_t;

  vec_t vecs[7];
  localparam int L = 4;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 0, 16'h0000, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h505A, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 0, 16'h0000, 16'h0020, 16'h1234, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h1234, 16'h505A, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 0, 16'h0020, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 1'b0, 16'h1234, 16'h1234, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b0, 16'h1234, 16'h1234, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 3, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b0, 16'h1234, 16'h1234, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 2, 16'h0040, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 1'b0, 16'h1234, 16'hCAFE, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1, 16'h0000, 16'h0030, 16'h0000, 1'b0, 1'b1, 16'h0030, 1'b0, 16'h0000, 16'hCAFE, 16'h305A};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 0, 16'(busy), 16'h0);
    chk("rst mem_en", 0, 16'(mem_en), 16'h0);
    chk("rst mem_addr", 0, mem_addr, 16'h0);
    chk("rst mem_wdata", 0, mem_wdata, 16'h0);
    chk("rst i_rdata", 0, i_rdata, 16'h0);
    chk("rst d_rdata", 0, d_rdata, 16'h0);
    chk("rst rdy", 0, {14'h0, i_rdy, d_rdy}, 16'h0);

    // Both requesters high from release: D first, then alternating
    @(posedge clk); #1;
    rst = 0;
    i_req = 1; i_addr = 16'h0050;
    d_req = 1; d_addr = 16'h0060; d_we = 0; d_wdata = 16'h0000;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (c == 24) begin i_req = 0; d_req = 0; end
      @(negedge clk);
      chk("alt mem_en", c, 16'(mem_en), 16'((c % 6) == 1));
      chk("alt busy", c, 16'(busy), 16'((c % 6) != 0));
      chk("alt d_rdy", c, 16'(d_rdy), 16'(c == 5 || c == 17));
      chk("alt i_rdy", c, 16'(i_rdy), 16'(c == 11 || c == 23));
      if (c == 1 || c == 13) chk("alt addr D", c, mem_addr, 16'h0060);
      if (c == 7 || c == 19) chk("alt addr I", c, mem_addr, 16'h0050);
      if (c == 5) chk("alt d_rdata", c, d_rdata, 16'h605A);
      if (c == 11) chk("alt i_rdata", c, i_rdata, 16'h505A);
    end

    // Table-driven single transactions on the LAT=4 instance
    for (int v = 0; v < 7; v++) begin
      i_req = vecs[v].ireq; i_addr = vecs[v].iaddr;
      d_req = vecs[v].dreq; d_we = vecs[v].dwe;
      d_addr = vecs[v].daddr; d_wdata = vecs[v].dwdata;
      i_kill = (vecs[v].kill_mode == 2);
      for (int c = 1; c <= L + 2; c++) begin
        @(posedge clk); #1;
        i_kill = (vecs[v].kill_mode == 1 && c == 2) || (vecs[v].kill_mode == 3 && c == L + 1);
        if (c == L + 2) begin i_req = 0; d_req = 0; end
        @(negedge clk);
        chk($sformatf("v%0d mem_en", v), c, 16'(mem_en), 16'(c == 1));
        chk($sformatf("v%0d mem_we", v), c, 16'(mem_we), 16'(c == 1 && vecs[v].exp_we));
        chk($sformatf("v%0d busy", v), c, 16'(busy), 16'(c <= L + 1));
        chk($sformatf("v%0d i_rdy", v), c, 16'(i_rdy), 16'(c == L + 1 && vecs[v].exp_i));
        chk($sformatf("v%0d d_rdy", v), c, 16'(d_rdy), 16'(c == L + 1 && vecs[v].exp_d));
        if (c == 1) begin
          chk($sformatf("v%0d mem_addr", v), c, mem_addr, vecs[v].exp_addr);
          chk($sformatf("v%0d mem_wdata", v), c, mem_wdata, vecs[v].exp_wdata);
        end
        if (c == L + 1 && vecs[v].exp_i) chk($sformatf("v%0d i_rdata", v), c, i_rdata, vecs[v].exp_ird);
        if (c == L + 1 && vecs[v].exp_d) chk($sformatf("v%0d d_rdata", v), c, d_rdata, vecs[v].exp_drd);
        if (c == L + 2) begin
          chk($sformatf("v%0d i_rdata hold", v), c, i_rdata, vecs[v].exp_ird);
          chk($sformatf("v%0d d_rdata hold", v), c, d_rdata, vecs[v].exp_drd);
          chk($sformatf("v%0d mem_addr hold", v), c, mem_addr, vecs[v].exp_addr);
        end
      end
    end

    // Asynchronous reset in the middle of WAIT
    d_req = 1; d_we = 0; d_addr = 16'h0010;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("pre-rst busy", 3, 16'(busy), 16'h1);
    #2 rst = 1;
    #1;
    chk("async busy", 3, 16'(busy), 16'h0);
    chk("async mem_en", 3, {14'h0, mem_en, mem_we}, 16'h0);
    chk("async rdy", 3, {14'h0, i_rdy, d_rdy}, 16'h0);
    chk("async mem_addr", 3, mem_addr, 16'h0);
    chk("async mem_wdata", 3, mem_wdata, 16'h0);
    chk("async i_rdata", 3, i_rdata, 16'h0);
    chk("async d_rdata", 3, d_rdata, 16'h0);
    d_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("post-rst busy", c, 16'(busy), 16'h0);
      chk("post-rst rdy", c, {14'h0, i_rdy, d_rdy}, 16'h0);
    end

    // LAT=1 back-to-back fetches
    i_req1 = 1; i_addr1 = 16'h0010;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 9) i_req1 = 0;
      @(negedge clk);
      chk("lat1 mem_en", c, 16'(mem_en1), 16'(c == 1 || c == 4 || c == 7));
      chk("lat1 i_rdy", c, 16'(i_rdy1), 16'(c == 2 || c == 5 || c == 8));
      chk("lat1 busy", c, 16'(busy1), 16'((c % 3) != 0));
      if (c == 2 || c == 5 || c == 8) chk("lat1 i_rdata", c, i_rdata1, 16'hBEEF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 4, is the memory read/write latency in cycles; legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 i_req  input  1  instruction-fetch request; held high until i_rdy.
REQ-005 i_addr  input  16  fetch address; stable while i_req high.
REQ-006 i_kill  input  1  flush; cancels an in-flight fetch.
REQ-007 i_rdy  output  1  one-cycle pulse; fetch complete.
REQ-008 i_rdata  output  16  fetched word; valid when i_rdy is high.
REQ-009 d_req  input  1  data request; held high until d_rdy.
REQ-010 d_we  input  1  1 = write, 0 = read; stable while d_req high.
REQ-011 d_addr  input  16  data address.
REQ-012 d_wdata  input  16  write data.
REQ-013 d_rdy  output  1  one-cycle pulse; data access complete.
REQ-014 d_rdata  output  16  read word; valid when d_rdy is high after a read.
REQ-015 mem_en  output  1  one-cycle issue strobe to the shared single-port memory.
REQ-016 mem_we  output  1  write enable; qualified by mem_en.
REQ-017 mem_addr  output  16  memory address.
REQ-018 mem_wdata  output  16  memory write data.
REQ-019 mem_rdata  input  16  memory read data; valid in the LAT-th cycle, counting the mem_en cycle as cycle 1.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states and transitions:
- IDLE -> ISSUE when any request is high.
- ISSUE -> WAIT.
- WAIT -> DONE when the latency counter expires.
- DONE -> IDLE unconditionally.
REQ-022 ISSUE: mem_en=1; mem_addr, mem_we and mem_wdata are registered from the granted requester; lasts exactly one cycle.
REQ-023 Counter: loaded with LAT-1 on entry to ISSUE; decrements each cycle thereafter. For LAT=1, ISSUE goes directly to DONE and mem_rdata is captured at the end of ISSUE.
REQ-024 mem_rdata is captured into the granted requester's rdata register at the end of cycle LAT; the rdy pulse is asserted in the DONE cycle.
REQ-025 Latency: request sampled at edge k -> mem_en in cycle k+1 -> rdy in cycle k+LAT+1.
REQ-026 Maximum throughput is one transaction per LAT+2 cycles.
REQ-027 Outside ISSUE, mem_en and mem_we are 0; mem_addr and mem_wdata hold their last values.
REQ-028 Arbitration happens only in IDLE. A single requester wins. When both are high, the requester not granted last wins; last_grant is updated at each grant.
REQ-029 In DONE, the served requester's still-high req is ignored; the other requester is not granted until IDLE.
REQ-030 Writes: d_rdy pulses with the same latency as reads; d_rdata is unchanged.
REQ-031 i_kill with the arbiter idle, or with a data transaction active: no effect.
REQ-032 i_kill high in any cycle of an active fetch (ISSUE, WAIT or DONE):
- the memory access still completes;
- i_rdy is suppressed for that transaction;
- i_rdata is unchanged.
REQ-033 i_kill concurrent with i_req in IDLE: the fetch is granted normally.
REQ-034 i_rdy and d_rdy are never high in the same cycle; at most one transaction is outstanding.
REQ-035 Requests dropped before rdy: the transaction completes on memory; rdy still pulses, ignored by the requester.

Reset
REQ-036 rst high forces, immediately and regardless of clk:
- state = IDLE, counter = 0, last_grant = I;
- i_rdy = d_rdy = mem_en = mem_we = busy = 0;
- i_rdata, d_rdata, mem_addr and mem_wdata = 0.
REQ-037 Reset mid-transaction abandons it; no rdy pulse is issued after reset releases.
REQ-038 The first cycle after release is IDLE and arbitrates normally.

Verification
REQ-039 LAT=4, d_req=1, d_we=0, d_addr=0x0010 sampled at edge 0, memory returns 0xBEEF in cycle 4 -> mem_en=1 in cycle 1 only; d_rdy=1 and d_rdata=0xBEEF in cycle 5; busy high in cycles 1-5.
REQ-040 i_req and d_req both high from reset release -> D granted first (mem_addr=d_addr); I is issued in the cycle after D's DONE+IDLE; order then alternates D, I, D, I.
REQ-041 d_req, d_we=1, d_addr=0x0020, d_wdata=0x1234 -> mem_en=1, mem_we=1, mem_addr=0x0020, mem_wdata=0x1234 for one cycle; d_rdy in cycle LAT+1; d_rdata unchanged.
REQ-042 Fetch in WAIT, i_kill pulsed one cycle -> no i_rdy; i_rdata keeps its previous value; arbiter returns to IDLE on schedule.
REQ-043 LAT=1, back-to-back i_req -> mem_en in cycles 1, 4, 7; i_rdy in cycles 2, 5, 8.
REQ-044 rst asserted mid-WAIT -> all outputs 0 without a clock edge; after release with no requests, busy stays 0 and no rdy pulse appears.
